// File: rtl/button_pkg.sv
// Shared types and default constants for the push-button one-pulse block.
package button_pkg;

    localparam int DB_CYCLES_DEF     = 16;
    localparam int REPEAT_CYCLES_DEF = 1024;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse the chain to one flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/button_onepulse.sv
// Debounced push-button to single-cycle press request plus debounced level.
// Optional auto-repeat while held: define ONEPULSE_REPEAT_EN.
module button_onepulse
    import button_pkg::*;
#(
    parameter int DB_CYCLES     = DB_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_in,
    output logic pulse,
    output logic pressed
);

    localparam int             CW       = $clog2(DB_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

    if (DB_CYCLES < 2) begin : g_bad_db
        $error("button_onepulse: DB_CYCLES must be >= 2");
    end
    if (REPEAT_CYCLES < 2) begin : g_bad_rep
        $error("button_onepulse: REPEAT_CYCLES must be >= 2");
    end

    logic          s2;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          pulse_n, pressed_n;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pb_in),
        .q   (s2)
    );

`ifdef ONEPULSE_REPEAT_EN
    localparam int             RW       = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0]  REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep, rep_n;
`endif

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pulse_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (s2) begin
                    state_n = PRESS_DB;
                    cnt_n   = '0;
                end
            end
            PRESS_DB: begin
                if (!s2) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = HELD;
                    cnt_n   = '0;
                    pulse_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!s2) begin
                    state_n = REL_DB;
                    cnt_n   = '0;
                end
            end
            REL_DB: begin
                if (s2) begin
                    state_n = HELD;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

`ifdef ONEPULSE_REPEAT_EN
        // Repeat timer runs only while staying in HELD; it freezes in REL_DB.
        rep_n = rep;
        if (state == PRESS_DB && state_n == HELD) begin
            rep_n = '0;
        end else if (state == HELD && state_n == HELD) begin
            if (rep == REP_LAST) begin
                rep_n   = '0;
                pulse_n = 1'b1;
            end else begin
                rep_n = rep + 1'b1;
            end
        end
`endif

        pressed_n = (state_n == HELD) || (state_n == REL_DB);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            pulse   <= 1'b0;
            pressed <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            pulse   <= pulse_n;
            pressed <= pressed_n;
        end
    end

`ifdef ONEPULSE_REPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rep <= '0;
        else     rep <= rep_n;
    end
`endif

endmodule
